// File: rtl/uart_pkg.sv
// Shared definitions for shared-UART blocks: arbiter state encoding, UART framing
// constants and the frame-length helper used to time a uart_tx frame without a busy flag.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

    localparam int UART_DATA_W     = 8;
    localparam int UART_START_BITS = 1;

    // Cycles from a start pulse until the line may be driven again, guard included.
    function automatic int frame_cycles(input int clks_per_bit, input int stop_bits,
                                        input int guard);
        return clks_per_bit * (UART_START_BITS + UART_DATA_W + stop_bits) + guard;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: returns the first set bit of valid found by
// searching upward from ptr+1 with wrap-around, plus a flag saying any bit was set.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [2*N-1:0] dbl;
    int             sel;

    // Doubling the vector turns the wrap-around search into a plain lowest-bit search.
    always_comb begin
        dbl = {valid, valid} >> (int'(ptr) + 1);
        any = |valid;
        sel = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                sel = j;
            end
        end
        sel = sel + int'(ptr) + 1;
        if (sel >= N) begin
            sel = sel - N;
        end
        winner = IW'(sel);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources; times each frame
// internally. Optional packet lock (sticky re-grant) is enabled by UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 32,
    parameter int STOP_BITS    = 1,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 uart_tx_input,
    output logic                       uart_tx_start,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int FRAME_CYCLES = frame_cycles(CLKS_PER_BIT, STOP_BITS, GUARD_CYCLES);
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
    localparam int IDW          = $clog2(NUM_REQ);

    // Handshake: a byte moves from requester i on a rising edge where req_valid[i] and
    // req_ready[i] are both high; ready is only offered in GRANT, to grant_id alone.
    arb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDW-1:0]   ptr, ptr_next;
    logic [IDW-1:0]   grant_next;
    logic [7:0]       data_next;
    logic             start_next;
    logic             lock_hit, lock_hit_next;
    logic             lock_last;
    logic [IDW-1:0]   rr_winner;
    logic             rr_any;
    logic [7:0]       grant_byte;

    rr_select #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr_select (
        .valid  (req_valid),
        .ptr    (ptr),
        .winner (rr_winner),
        .any    (rr_any)
    );

    assign grant_byte = req_data[{grant_id, 3'b000} +: 8];
    assign busy       = (state != IDLE);

`ifdef UART_TX_ARB_LOCK_EN
    assign lock_last = req_lock[grant_id] & req_valid[grant_id];
`else
    assign lock_last = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        ptr_next      = ptr;
        grant_next    = grant_id;
        data_next     = uart_tx_input;
        start_next    = 1'b0;
        lock_hit_next = lock_hit;
        req_ready     = '0;
        case (state)
            IDLE: begin
                lock_hit_next = 1'b0;
                if (lock_hit) begin
                    state_next = GRANT;
                end else if (rr_any) begin
                    grant_next = rr_winner;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id] = 1'b1;
                // A withdrawn valid leaves the pointer alone so the same order is retried.
                if (req_valid[grant_id]) begin
                    data_next  = grant_byte;
                    ptr_next   = grant_id;
                    start_next = 1'b1;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                cnt_next   = CNT_W'(FRAME_CYCLES - 1);
                state_next = WAIT;
            end
            WAIT: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    lock_hit_next = lock_last;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            ptr           <= IDW'(NUM_REQ - 1);
            grant_id      <= '0;
            uart_tx_input <= '0;
            uart_tx_start <= 1'b0;
            lock_hit      <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            ptr           <= ptr_next;
            grant_id      <= grant_next;
            uart_tx_input <= data_next;
            uart_tx_start <= start_next;
            lock_hit      <= lock_hit_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle-timeline model of the arbitration rules is
// compared against the DUT on every cycle, with literal start times and byte order checks.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 32 * (1 + 8 + 1) + 2;  // 322

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_tx_input;
    logic           uart_tx_start;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N-1:0]   req_lock = '0;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_lock      (req_lock),
`endif
        .req_ready     (req_ready),
        .uart_tx_input (uart_tx_input),
        .uart_tx_start (uart_tx_start),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester sources ----------------
    logic [7:0] src_mem [N][4];
    int         src_cnt [N];
    int         src_rd  [N];
    bit         pending [N];
    bit         withdraw[N];

    task automatic present(input int i);
        if (src_rd[i] < src_cnt[i]) begin
            req_valid[i]        = 1'b1;
            req_data[8*i +: 8]  = src_mem[i][src_rd[i]];
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic load(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2);
        src_mem[i][0] = b0;
        src_mem[i][1] = b1;
        src_mem[i][2] = b2;
        src_cnt[i]    = n;
        src_rd[i]     = 0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_cnt[i]  = 0;
            src_rd[i]   = 0;
            pending[i]  = 0;
            withdraw[i] = 0;
        end
        req_valid = '0;
        req_data  = '0;
`ifdef UART_TX_ARB_LOCK_EN
        req_lock  = '0;
`endif
    endtask

    // One cycle: advance sources that transferred last edge, then note new handshakes.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                pending[i] = 0;
                src_rd[i]++;
                present(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) begin
                if (withdraw[i]) begin
                    withdraw[i]  = 0;
                    req_valid[i] = 1'b0;
                    src_rd[i]++;
                end else begin
                    pending[i] = 1;
                end
            end
        end
    endtask

    // ---------------- timeline model ----------------
    // Cycle n is busy iff dec < n < idle_from; ready is offered at dec+1; start at start_at.
    int         cyc, dec, idle_from, start_at, m_ptr, m_win, m_w;
    logic [7:0] m_data;
    logic [1:0] m_grant;
    bit         m_lock;

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; dec = -10; idle_from = 0; start_at = -10;
            m_ptr = N - 1; m_win = 0; m_data = 8'h00; m_grant = 2'd0; m_lock = 0;
        end else begin
            if (cyc >= idle_from) begin
                m_w    = m_lock ? m_win : rr_pick(m_ptr, req_valid);
                m_lock = 0;
                if (m_w >= 0) begin
                    m_win     = m_w;
                    m_grant   = 2'(m_w);
                    dec       = cyc;
                    idle_from = cyc + FRAME + 2;
                end
            end else if (cyc == dec + 1) begin
                if (req_valid[m_win]) begin
                    m_ptr    = m_win;
                    m_data   = req_data[8*m_win +: 8];
                    start_at = cyc + 1;
                end else begin
                    idle_from = cyc + 1;
                end
            end else if (cyc == idle_from - 1) begin
`ifdef UART_TX_ARB_LOCK_EN
                m_lock = req_lock[m_win] && req_valid[m_win];
`endif
            end
            cyc++;
        end
    end

    // ---------------- compare process and scoreboard ----------------
    logic [7:0] exp_q[$];
    int         start_log[$];
    int         busy_cnt;
    int         rdy_cnt[N];
    logic [N-1:0] exp_rdy;

    always @(negedge clk) begin
        if (reset) begin
            exp_rdy = '0;
            if (cyc == dec + 1) exp_rdy[m_win] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("uart_tx_start", 32'(uart_tx_start), 32'(cyc == start_at));
            check("busy", 32'(busy), 32'(cyc > dec && cyc < idle_from));
            check("grant_id", 32'(grant_id), 32'(m_grant));
            check("uart_tx_input", 32'(uart_tx_input), 32'(m_data));
            if (busy) busy_cnt++;
            for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
            if (uart_tx_start) begin
                start_log.push_back(cyc);
                if (exp_q.size() == 0) check("unexpected_start", 32'(uart_tx_input), 32'hFFFF);
                else check("start_byte", 32'(uart_tx_input), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_log();
        start_log.delete();
        busy_cnt = 0;
        for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_cnt[i] || pending[i]) return 0;
        end
        return !busy && exp_q.size() == 0;
    endfunction

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while (!all_done() && n < budget) begin
            step();
            n++;
        end
        check({name, "_done"}, 32'(all_done()), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_start"}, 32'(uart_tx_start), 32'h0);
        check({tag, "_input"}, 32'(uart_tx_input), 32'h00);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_grant"}, 32'(grant_id), 32'h0);
    endtask

    task automatic do_reset(input logic [N-1:0] v_during, input string tag);
        reset = 1'b0;
        clear_sources();
        exp_q.delete();
        req_valid = v_during;
        repeat (10) @(negedge clk);
        check_reset_outputs(tag);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        clear_log();
    endtask

    int c0;
    int n;

    initial begin
        clear_sources();
        clear_log();
        #1 reset = 1'b0;

        // Reset with every requester asserting valid.
        do_reset(4'hF, "rst");

        // Single request from requester 0.
        load(0, 1, 8'h34, 8'h00, 8'h00);
        exp_q.push_back(8'h34);
        present(0);
        c0 = cyc;
        run_until_done(2000, "single");
        check("single_nstart", 32'(start_log.size()), 32'd1);
        if (start_log.size() == 1) check("single_start_at", 32'(start_log[0] - c0), 32'd2);
        check("single_busy_len", 32'(busy_cnt), 32'd323);

        // All four valid together after reset: served 0,1,2,3.
        do_reset(4'h0, "rst2");
        load(0, 1, 8'h55, 8'h00, 8'h00);
        load(1, 1, 8'hA0, 8'h00, 8'h00);
        load(2, 1, 8'h0F, 8'h00, 8'h00);
        load(3, 1, 8'hC3, 8'h00, 8'h00);
        exp_q.push_back(8'h55); exp_q.push_back(8'hA0);
        exp_q.push_back(8'h0F); exp_q.push_back(8'hC3);
        for (int i = 0; i < N; i++) present(i);
        c0 = cyc;
        run_until_done(3000, "all4");
        check("all4_nstart", 32'(start_log.size()), 32'd4);
        if (start_log.size() == 4) begin
            check("all4_first_at", 32'(start_log[0] - c0), 32'd2);
            for (int i = 0; i < 3; i++)
                check("all4_spacing", 32'(start_log[i+1] - start_log[i]), 32'd324);
        end

        // Requester 2 withdraws during GRANT; its successor 3 is served next.
        @(negedge clk);
        clear_log();
        load(2, 1, 8'hEE, 8'h00, 8'h00);
        load(3, 1, 8'h5A, 8'h00, 8'h00);
        withdraw[2] = 1;
        exp_q.push_back(8'h5A);
        present(2);
        present(3);
        c0 = cyc;
        run_until_done(2000, "withdraw");
        check("withdraw_rdy2", 32'(rdy_cnt[2]), 32'd1);
        check("withdraw_rdy3", 32'(rdy_cnt[3]), 32'd1);
        check("withdraw_nstart", 32'(start_log.size()), 32'd1);
        if (start_log.size() == 1) check("withdraw_start_at", 32'(start_log[0] - c0), 32'd4);

        // Reset asserted 100 cycles into WAIT.
        @(negedge clk);
        clear_log();
        load(1, 1, 8'h77, 8'h00, 8'h00);
        exp_q.push_back(8'h77);
        present(1);
        n = 0;
        while (!uart_tx_start && n < 1000) begin
            step();
            n++;
        end
        check("midrst_start_seen", 32'(uart_tx_start), 32'd1);
        repeat (100) step();
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        clear_sources();
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst_hold");
        load(0, 1, 8'h11, 8'h00, 8'h00);
        load(1, 1, 8'h22, 8'h00, 8'h00);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        present(0);
        present(1);
        clear_log();
        reset = 1'b1;
        run_until_done(2000, "after_rst");
        check("after_rst_nstart", 32'(start_log.size()), 32'd2);
        if (start_log.size() == 2) begin
            check("after_rst_first_at", 32'(start_log[0]), 32'd2);
            check("after_rst_spacing", 32'(start_log[1] - start_log[0]), 32'd324);
        end

`ifdef UART_TX_ARB_LOCK_EN
        // Locked 3-byte packet from requester 1 stays contiguous ahead of requester 0.
        do_reset(4'h0, "rst3");
        load(1, 3, 8'h81, 8'h82, 8'h83);
        req_lock[1] = 1'b1;
        present(1);
        exp_q.push_back(8'h81); exp_q.push_back(8'h82);
        exp_q.push_back(8'h83); exp_q.push_back(8'h90);
        step();
        load(0, 1, 8'h90, 8'h00, 8'h00);
        present(0);
        run_until_done(3000, "lock");
        check("lock_nstart", 32'(start_log.size()), 32'd4);
        if (start_log.size() == 4) begin
            for (int i = 0; i < 3; i++)
                check("lock_spacing", 32'(start_log[i+1] - start_log[i]), 32'd324);
        end
`else
        // One requester with two bytes is served back-to-back at the frame rate.
        @(negedge clk);
        clear_log();
        load(1, 2, 8'h81, 8'h82, 8'h00);
        exp_q.push_back(8'h81); exp_q.push_back(8'h82);
        present(1);
        run_until_done(2000, "b2b");
        check("b2b_nstart", 32'(start_log.size()), 32'd2);
        if (start_log.size() == 2)
            check("b2b_spacing", 32'(start_log[1] - start_log[0]), 32'd324);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
